// File: rtl/window_gen_3x3.sv
// Raster pixel stream -> registered 3x3 neighbourhood over two row line buffers; outputs one cycle after the pixel edge.
// No backpressure: every pix_valid beat is consumed, and idle beats hold state while dropping win_valid/frame_done.
module window_gen_3x3 #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pix_in,
  input  logic       pix_valid,
  input  logic       frame_start,
  output logic [7:0] p1,
  output logic [7:0] p2,
  output logic [7:0] p3,
  output logic [7:0] p4,
  output logic [7:0] p5,
  output logic [7:0] p6,
  output logic [7:0] p7,
  output logic [7:0] p8,
  output logic [7:0] p9,
  output logic       win_valid,
  output logic       frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [7:0]    lb0 [IMG_W];
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    top;
  logic [7:0]    mid;

  // frame_start re-anchors the accepted pixel at (0,0) regardless of counters
  assign c   = frame_start ? '0 : col;
  assign r   = frame_start ? '0 : row;
  assign top = lb1[c];
  assign mid = lb0[c];

  // Line buffers carry no reset; win_valid gating keeps stale rows hidden.
  always_ff @(posedge clk) begin
    if (rst && pix_valid) begin
      lb1[c] <= lb0[c];
      lb0[c] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      p1         <= '0;
      p2         <= '0;
      p3         <= '0;
      p4         <= '0;
      p5         <= '0;
      p6         <= '0;
      p7         <= '0;
      p8         <= '0;
      p9         <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else if (pix_valid) begin
      p1         <= p2;
      p2         <= p3;
      p3         <= top;
      p4         <= p5;
      p5         <= p6;
      p6         <= mid;
      p7         <= p8;
      p8         <= p9;
      p9         <= pix_in;
      win_valid  <= (r >= RW'(2)) && (c >= CW'(2));
      frame_done <= 1'b0;
      if (c == COL_LAST) begin
        col <= '0;
        if (r == ROW_LAST) begin
          row        <= '0;
          frame_done <= 1'b1;
        end else begin
          row <= r + RW'(1);
        end
      end else begin
        col <= c + CW'(1);
        row <= r;
      end
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboarded bench: drivers push per-cycle expectations, a negedge monitor pops and compares.
module tb_window_gen_3x3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pix_in;
  logic       pix_valid;
  logic       frame_start;
  logic [7:0] a [9];
  logic [7:0] b [9];
  logic       a_wv, a_fd, b_wv, b_fd;

  always #5 clk = ~clk;

  window_gen_3x3 #(.IMG_W(4), .IMG_H(4)) dut4 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .frame_start(frame_start),
    .p1(a[0]), .p2(a[1]), .p3(a[2]), .p4(a[3]), .p5(a[4]), .p6(a[5]), .p7(a[6]), .p8(a[7]), .p9(a[8]),
    .win_valid(a_wv), .frame_done(a_fd)
  );

  window_gen_3x3 #(.IMG_W(3), .IMG_H(3)) dut3 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .frame_start(frame_start),
    .p1(b[0]), .p2(b[1]), .p3(b[2]), .p4(b[3]), .p5(b[4]), .p6(b[5]), .p7(b[6]), .p8(b[7]), .p9(b[8]),
    .win_valid(b_wv), .frame_done(b_fd)
  );

  typedef struct {
    bit          vld;
    bit          fd;
    bit          chkwin;
    bit          hold;
    logic [71:0] win;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  int          total = 0;
  int          bad   = 0;
  int          nwin  = 0;
  bit          sel   = 1'b0;
  int          cur_w = 4;
  int          cur_h = 4;
  logic [71:0] obs;
  logic [71:0] last = '0;
  logic        ov, ofd;

  assign obs = sel ? {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7], b[8]}
                   : {a[0], a[1], a[2], a[3], a[4], a[5], a[6], a[7], a[8]};
  assign ov  = sel ? b_wv : a_wv;
  assign ofd = sel ? b_fd : a_fd;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      total++;
      if (ov !== me.vld) begin
        bad++;
        $display("FAIL win_valid: got %b want %b at %0t", ov, me.vld, $time);
      end
      total++;
      if (ofd !== me.fd) begin
        bad++;
        $display("FAIL frame_done: got %b want %b at %0t", ofd, me.fd, $time);
      end
      if (me.chkwin) begin
        total++;
        if (obs !== me.win) begin
          bad++;
          $display("FAIL window: got %h want %h at %0t", obs, me.win, $time);
        end
      end
      if (me.hold) begin
        total++;
        if (obs !== last) begin
          bad++;
          $display("FAIL hold: got %h want %h at %0t", obs, last, $time);
        end
      end
      if (ov === 1'b1) nwin++;
    end
    last = obs;
  end

  function automatic logic [7:0] pv(int r, int c, int off);
    return 8'(off + 16 * r + c);
  endfunction

  // Window for pixel (r,c): rows r-2..r top to bottom, columns c-2..c left to right
  function automatic logic [71:0] exp_win(int r, int c, int off);
    logic [71:0] w = '0;
    for (int rr = r - 2; rr <= r; rr++)
      for (int cc = c - 2; cc <= c; cc++)
        w = {w[63:0], pv(rr, cc, off)};
    return w;
  endfunction

  task automatic drive(bit rn, bit v, bit fs, logic [7:0] px, exp_t e);
    rst = rn; pix_valid = v; frame_start = fs; pix_in = px;
    @(posedge clk);
    q.push_back(e);
    #1;
  endtask

  task automatic pix(int r, int c, int off, bit fs, bit gap);
    exp_t e;
    e.vld    = (r >= 2) && (c >= 2);
    e.fd     = (r == cur_h - 1) && (c == cur_w - 1);
    e.chkwin = e.vld;
    e.hold   = 1'b0;
    e.win    = e.vld ? exp_win(r, c, off) : '0;
    drive(1'b1, 1'b1, fs, pv(r, c, off), e);
    if (gap) begin
      e.vld = 1'b0; e.fd = 1'b0; e.chkwin = 1'b0; e.hold = 1'b1;
      drive(1'b1, 1'b0, 1'b1, 8'hEE, e);
    end
  endtask

  task automatic frame(int off, bit gap, bit fs0);
    for (int r = 0; r < cur_h; r++)
      for (int c = 0; c < cur_w; c++)
        pix(r, c, off, fs0 && (r == 0) && (c == 0), gap);
  endtask

  task automatic do_reset();
    exp_t e;
    e.vld = 1'b0; e.fd = 1'b0; e.chkwin = 1'b1; e.hold = 1'b0; e.win = '0;
    drive(1'b0, 1'b1, 1'b1, 8'hFF, e);
  endtask

  task automatic check_count(int want, string name);
    exp_t e;
    e.vld = 1'b0; e.fd = 1'b0; e.chkwin = 1'b0; e.hold = 1'b1; e.win = '0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, e);
    @(negedge clk);
    #1;
    total++;
    if (nwin != want) begin
      bad++;
      $display("FAIL count %s: got %0d want %0d", name, nwin, want);
    end
    nwin = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    nwin = 0;
    frame(0, 1'b0, 1'b1);
    check_count(4, "basic");

    frame(0, 1'b1, 1'b1);
    check_count(4, "gapped");

    frame(0, 1'b0, 1'b1);
    frame(8'h80, 1'b0, 1'b1);
    check_count(8, "back_to_back");

    for (int c = 0; c < 4; c++) pix(0, c, 0, c == 0, 1'b0);
    pix(1, 0, 0, 1'b0, 1'b0);
    pix(1, 1, 0, 1'b0, 1'b0);
    frame(8'h40, 1'b0, 1'b1);
    check_count(4, "restart_mid");

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (r == 3 && c == 3) pix(0, 0, 8'h40, 1'b1, 1'b0);
        else pix(r, c, 0, (r == 0) && (c == 0), 1'b0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (r != 0 || c != 0) pix(r, c, 8'h40, 1'b0, 1'b0);
    check_count(7, "restart_last");

    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++) pix(r, c, 0, (r == 0) && (c == 0), 1'b0);
    pix(3, 0, 0, 1'b0, 1'b0);
    do_reset();
    nwin = 0;
    frame(0, 1'b0, 1'b0);
    check_count(4, "after_reset");

    sel   = 1'b1;
    cur_w = 3;
    cur_h = 3;
    do_reset();
    nwin = 0;
    frame(0, 1'b0, 1'b1);
    check_count(1, "min_size");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Upstream feeder for the median/difference filter pipeline. It accepts a raster-order 8-bit pixel stream, buffers the two previous image rows in on-chip line buffers, and presents a registered 3x3 neighbourhood on p1..p9 together with a window-valid strobe. It sits directly in front of `stage1`: p1..p9 map 1:1 onto its inputs, and win_valid drives its `act`.

## Interface
Parameters:
- IMG_W, default 8: pixels per row; legal range ≥3.
- IMG_H, default 8: rows per frame; legal range ≥3.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, active-low, synchronous. One clock; reset is synchronous and active-low.
- pix_in  in  8  incoming pixel, raster order.
- pix_valid  in  1  pix_in is accepted this cycle. No backpressure is provided.
- frame_start  in  1  qualified by pix_valid; marks the accepted pixel as (row 0, col 0).
- p1..p9  out  8 each  registered window. p1 p2 p3 form the top row (oldest line); p4 p5 p6 the middle row; p7 p8 p9 the bottom (current) row. Left to right is oldest to newest column; p5 is the centre and p9 the newest pixel.
- win_valid  out  1  p1..p9 hold a complete in-image window this cycle.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- State:
  - col counter, 0..IMG_W-1.
  - row counter, 0..IMG_H-1.
  - Line buffers lb0 (previous row) and lb1 (row before that), IMG_W x 8 each, indexed by col.
  - 3x3 window register.
- On each accepted pixel (pix_valid=1), at current col c:
  - Read top=lb1[c] and mid=lb0[c].
  - Write lb1[c]<=lb0[c] and lb0[c]<=pix_in.
  - Shift the window left: p1<=p2, p2<=p3, p3<=top; p4<=p5, p5<=p6, p6<=mid; p7<=p8, p8<=p9, p9<=pix_in.
  - win_valid <= (row≥2 && c≥2).
  - Advance counters: if c==IMG_W-1, col wraps to 0 and row increments.
  - If additionally row==IMG_H-1, row wraps to 0 and frame_done <= 1.
- frame_start=1 with pix_valid=1 forces the accepted pixel to be treated as col=0, row=0, then counters continue from there. A mid-frame frame_start therefore abandons the current frame and emits no frame_done for it.
- No windows are produced for border pixels (no padding). Valid windows per frame = (IMG_W-2)*(IMG_H-2).
- Windows straddling a row boundary (c<2) are shifted but never flagged valid.
- Cycles with pix_valid=0: counters, line buffers and p1..p9 hold; win_valid<=0; frame_done<=0.
- Line buffer contents are not reset. Stale data is never exposed, because win_valid gating requires two fresh rows after reset or frame_start.
- Arithmetic is width-preserving only. No pixel values are modified.

## Timing
- Reset (rst=0 at a clk edge): p1..p9=0, win_valid=0, frame_done=0, col=0, row=0, all effective at that edge.
- Reset has priority over pix_valid and frame_start. Reset mid-frame discards progress; the next accepted pixel is (0,0).
- Latency: a pixel accepted at edge t appears on p9 after edge t, i.e. in cycle t+1. win_valid and frame_done are also registered at edge t.
- win_valid is high for exactly one cycle per qualifying accepted pixel. Back-to-back pixels give back-to-back valid windows within a row.
- Throughput: one pixel per clock, sustained, including across frame boundaries. frame_start on the pixel immediately after a frame_done pulse is legal.
- Simultaneous events: frame_start on the last pixel position of a frame takes priority, so no frame_done is emitted.

## Test plan
- IMG_W=4, IMG_H=4. Stream pixel value 16*row+col continuously, frame_start on the first pixel.
  - First win_valid arrives the cycle after pixel (2,2) is accepted.
  - Window: p1..p9 = 0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22.
  - Exactly 4 valid windows per frame.
  - frame_done pulses once, the cycle after pixel 0x33 is accepted.
- Same stream with pix_valid toggled 1,0,1,0:
  - Identical window contents and count.
  - win_valid is never high in a cycle that follows a pix_valid=0 cycle.
  - Outputs hold during gaps.
- Two frames back-to-back with no idle cycle, second frame values +0x80:
  - Second frame's first valid window is p5=0x91 and p9=0xA2.
  - No window mixes pixels from the two frames.
- frame_start asserted at pixel (1,2) of a frame:
  - No frame_done for the abandoned frame.
  - The next valid window occurs only after two new complete rows plus 3 pixels.
- rst=0 for one cycle mid-frame while win_valid is toggling:
  - Next cycle: all outputs are 0.
  - Restreaming the frame reproduces the first scenario's results exactly.
- IMG_W=3, IMG_H=3 (minimum size):
  - Exactly one valid window, on the 9th accepted pixel.
  - frame_done is asserted in the same cycle as that win_valid.
